// File: rtl/mspe_pkg.sv
// Shared constants, FSM state type and address helper for the MSPE DRAM writer.
package mspe_pkg;

   localparam int unsigned BEAT_W     = 512;
   localparam int unsigned BEAT_BYTES = 64;
   localparam int unsigned BEAT_SHIFT = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_BURST,
      ST_DONE
   } wr_state_t;

   // Byte address of beat idx relative to a 64-byte aligned base.
   function automatic logic [63:0] beat_addr(input logic [63:0]           base,
                                             input logic [63-BEAT_SHIFT:0] idx);
      return base + {idx, {BEAT_SHIFT{1'b0}}};
   endfunction

endpackage

// File: rtl/mspe_beat_fifo.sv
// First-word-fall-through synchronous beat FIFO with flush; flush overrides push/pop.
module mspe_beat_fifo
   import mspe_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = BEAT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int unsigned    PW       = $clog2(DEPTH);
   localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~flush & (count_q != FULL_CNT);
   assign do_pop  = pop  & ~flush & (count_q != '0);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == FULL_CNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mspe_dram_writer.sv
// Stream-to-DRAM burst writer: buffers the MSPE result stream and drains it as
// Avalon-MM write bursts at consecutive 64-byte addresses from a programmed base.
module mspe_dram_writer
   import mspe_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  clear,
   input  logic [63:0]           dst_addr_offset,
   input  logic [BEAT_W-1:0]     src_data,
   input  logic                  src_valid,
   input  logic                  src_sop,
   input  logic                  src_eop,
   output logic                  src_ready,
   input  logic                  m_waitrequest,
   output logic [63:0]           m_address,
   output logic [2:0]            m_burstcount,
   output logic [BEAT_W-1:0]     m_writedata,
   output logic                  m_write,
   output logic                  m_read,
   output logic [BEAT_BYTES-1:0] m_byteenable,
   output logic                  busy,
   output logic                  done,
   output logic [63:0]           beat_count
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   wr_state_t     state_q;
   logic          eop_seen_q;
   logic          clear_pend_q;
   logic          done_q;
   logic          m_write_q;
   logic [63:0]   dst_q;
   logic [63:0]   m_address_q;
   logic [63:0]   beat_count_q;
   logic [2:0]    m_burstcount_q;
   logic [2:0]    remain_q;

   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          push;
   logic          beat_taken;
   logic          last_beat;
   logic          clear_now;
   logic          start_go;
   logic          flush;
   logic          launch;
   logic [2:0]    launch_len;
   logic          unused_sop;

   assign unused_sop = src_sop;

   assign busy       = (state_q == ST_ARMED) || (state_q == ST_BURST);
   assign src_ready  = busy & ~fifo_full & ~eop_seen_q;
   assign push       = src_valid & src_ready;
   assign beat_taken = m_write_q & ~m_waitrequest;
   assign last_beat  = beat_taken && (remain_q == 3'd1);
   assign clear_now  = clear | clear_pend_q;
   assign start_go   = start & ~clear & ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign flush      = start_go | (clear && (state_q != ST_BURST)) | (last_beat & clear_now);

   always_comb begin
      launch     = 1'b0;
      launch_len = 3'(MAX_BURST);
      if (fifo_count >= CW'(MAX_BURST)) begin
         launch = 1'b1;
      end else if (eop_seen_q && (fifo_count != '0)) begin
         launch     = 1'b1;
         launch_len = 3'(fifo_count);
      end
   end

   mspe_beat_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BEAT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (beat_taken),
      .flush (flush),
      .wdata (src_data),
      .rdata (m_writedata),
      .count (fifo_count),
      .full  (fifo_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         eop_seen_q     <= 1'b0;
         clear_pend_q   <= 1'b0;
         done_q         <= 1'b0;
         m_write_q      <= 1'b0;
         dst_q          <= '0;
         m_address_q    <= '0;
         beat_count_q   <= '0;
         m_burstcount_q <= 3'd1;
         remain_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (clear) begin
                  beat_count_q <= '0;
                  eop_seen_q   <= 1'b0;
                  done_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end else if (start) begin
                  dst_q        <= dst_addr_offset;
                  beat_count_q <= '0;
                  eop_seen_q   <= 1'b0;
                  done_q       <= 1'b0;
                  state_q      <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (push && src_eop) eop_seen_q <= 1'b1;
               if (clear) begin
                  beat_count_q <= '0;
                  eop_seen_q   <= 1'b0;
                  state_q      <= ST_IDLE;
               end else if (launch) begin
                  // Beats issued so far equals beat_count here: bursts never overlap.
                  m_address_q    <= beat_addr(dst_q, beat_count_q[63-BEAT_SHIFT:0]);
                  m_burstcount_q <= launch_len;
                  remain_q       <= launch_len;
                  m_write_q      <= 1'b1;
                  state_q        <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (push && src_eop) eop_seen_q <= 1'b1;
               if (clear) clear_pend_q <= 1'b1;
               if (beat_taken) begin
                  beat_count_q <= beat_count_q + 64'd1;
                  remain_q     <= remain_q - 3'd1;
                  if (remain_q == 3'd1) begin
                     m_write_q    <= 1'b0;
                     clear_pend_q <= 1'b0;
                     // A clear seen during the burst is honoured only once it is complete.
                     if (clear_now) begin
                        beat_count_q <= '0;
                        eop_seen_q   <= 1'b0;
                        state_q      <= ST_IDLE;
                     end else if (eop_seen_q && (fifo_count == CW'(1))) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                     end else begin
                        state_q <= ST_ARMED;
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m_address    = m_address_q;
   assign m_burstcount = m_burstcount_q;
   assign m_write      = m_write_q;
   assign m_read       = 1'b0;
   assign m_byteenable = '1;
   assign done         = done_q;
   assign beat_count   = beat_count_q;

endmodule

// File: tb/tb_mspe_dram_writer.sv
// Directed bench for mspe_dram_writer: frames, burst splitting, waitrequest stalls,
// backpressure, clear mid-burst and asynchronous reset mid-burst.
module tb_mspe_dram_writer;

   logic         clk = 1'b0;
   logic         reset, start, clear;
   logic [63:0]  dst_addr_offset;
   logic [511:0] src_data;
   logic         src_valid, src_sop, src_eop, src_ready;
   logic         m_waitrequest;
   logic [63:0]  m_address;
   logic [2:0]   m_burstcount;
   logic [511:0] m_writedata;
   logic         m_write, m_read;
   logic [63:0]  m_byteenable;
   logic         busy, done;
   logic [63:0]  beat_count;

   always #5 clk = ~clk;

   mspe_dram_writer #(
      .FIFO_DEPTH (8),
      .MAX_BURST  (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .clear           (clear),
      .dst_addr_offset (dst_addr_offset),
      .src_data        (src_data),
      .src_valid       (src_valid),
      .src_sop         (src_sop),
      .src_eop         (src_eop),
      .src_ready       (src_ready),
      .m_waitrequest   (m_waitrequest),
      .m_address       (m_address),
      .m_burstcount    (m_burstcount),
      .m_writedata     (m_writedata),
      .m_write         (m_write),
      .m_read          (m_read),
      .m_byteenable    (m_byteenable),
      .busy            (busy),
      .done            (done),
      .beat_count      (beat_count)
   );

   int unsigned  total = 0;
   int unsigned  bad   = 0;
   logic [511:0] wr_data [$];
   logic [63:0]  b_addr  [$];
   int unsigned  b_len   [$];
   int           left;
   int unsigned  src_total, src_sent, src_tag;
   int unsigned  hold_left, hold_at, stall_seen;
   int unsigned  wb, bb, n;
   logic         wr_force, chk_stall;

   function automatic logic [511:0] beat_data(input int unsigned tag, input int unsigned i);
      logic [511:0] d;
      for (int unsigned k = 0; k < 16; k++) d[k*32 +: 32] = (tag << 24) | (i << 8) | k;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs on the falling edge, then note what the next rising edge transfers.
   task automatic cyc();
      @(negedge clk);
      if (wr_force) m_waitrequest = 1'b1;
      else if (hold_left != 0 && m_write && (wr_data.size() - wb) == hold_at) begin
         m_waitrequest = 1'b1;
         hold_left--;
      end else m_waitrequest = 1'b0;
      if (src_sent < src_total) begin
         src_valid = 1'b1;
         src_data  = beat_data(src_tag, src_sent);
         src_sop   = (src_sent == 0);
         src_eop   = (src_sent == src_total - 1);
      end else begin
         src_valid = 1'b0;
         src_sop   = 1'b0;
         src_eop   = 1'b0;
      end
      #1;
      if (src_valid && src_ready) src_sent++;
      if (m_write && !m_waitrequest) begin
         if (left <= 0) begin
            b_addr.push_back(m_address);
            b_len.push_back(int'(m_burstcount));
            left = int'(m_burstcount);
         end
         wr_data.push_back(m_writedata);
         left--;
      end
      if (chk_stall && m_write && m_waitrequest) begin
         stall_seen++;
         chk("stall_addr", m_address, 64'h3000);
         chk("stall_len", m_burstcount, 3'd4);
         chk("stall_data", m_writedata, beat_data(3, 1));
      end
   endtask

   task automatic frame(input int unsigned tag, input int unsigned nb, input logic [63:0] dst);
      wb        = wr_data.size();
      bb        = b_addr.size();
      src_tag   = tag;
      src_total = nb;
      src_sent  = 0;
      dst_addr_offset = dst;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic run_done(input string tag, input int unsigned budget);
      int unsigned k = 0;
      while (!done && k < budget) begin
         cyc();
         k++;
      end
      chk({tag, "_done"}, done, 1'b1);
   endtask

   task automatic chk_burst(input string tag, input int unsigned k, input logic [63:0] a, input int unsigned l);
      chk({tag, "_addr"}, b_addr[bb + k], a);
      chk({tag, "_len"}, b_len[bb + k], l);
   endtask

   task automatic chk_data(input string tag, input int unsigned tagv, input int unsigned nb);
      chk({tag, "_nbeats"}, wr_data.size() - wb, nb);
      for (int unsigned i = 0; i < nb; i++) chk({tag, "_data"}, wr_data[wb + i], beat_data(tagv, i));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; clear = 1'b0;
      src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_data = '0;
      m_waitrequest = 1'b0; dst_addr_offset = '0;
      left = 0; src_total = 0; src_sent = 0; src_tag = 0;
      hold_left = 0; hold_at = 0; stall_seen = 0; wb = 0; bb = 0; n = 0;
      wr_force = 1'b0; chk_stall = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_m_write", m_write, 1'b0);
      chk("rst_m_read", m_read, 1'b0);
      chk("rst_burstcount", m_burstcount, 3'd1);
      chk("rst_address", m_address, 64'h0);
      chk("rst_byteenable", m_byteenable, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_src_ready", src_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_beat_count", beat_count, 64'd0);
      reset = 1'b1;
      cyc();
      chk("idle_src_ready", src_ready, 1'b0);

      // 8 beats -> two full bursts
      frame(1, 8, 64'h1000);
      chk("t1_busy", busy, 1'b1);
      run_done("t1", 60);
      chk("t1_nbursts", b_addr.size() - bb, 2);
      chk_burst("t1_b0", 0, 64'h1000, 4);
      chk_burst("t1_b1", 1, 64'h1100, 4);
      chk_data("t1", 1, 8);
      chk("t1_beat_count", beat_count, 64'd8);
      chk("t1_busy_end", busy, 1'b0);
      chk("t1_src_ready_end", src_ready, 1'b0);

      // 6 beats -> full burst then a short eop burst
      frame(2, 6, 64'h2000);
      chk("t2_done_cleared", done, 1'b0);
      chk("t2_count_zeroed", beat_count, 64'd0);
      run_done("t2", 60);
      chk("t2_nbursts", b_addr.size() - bb, 2);
      chk_burst("t2_b0", 0, 64'h2000, 4);
      chk_burst("t2_b1", 1, 64'h2100, 2);
      chk_data("t2", 2, 6);
      chk("t2_beat_count", beat_count, 64'd6);

      // waitrequest held 3 cycles on the second beat
      hold_at = 1; hold_left = 3; stall_seen = 0; chk_stall = 1'b1;
      frame(3, 4, 64'h3000);
      run_done("t3", 60);
      chk_stall = 1'b0;
      chk("t3_stall_cycles", stall_seen, 3);
      chk("t3_nbursts", b_addr.size() - bb, 1);
      chk_burst("t3_b0", 0, 64'h3000, 4);
      chk_data("t3", 3, 4);
      chk("t3_beat_count", beat_count, 64'd4);

      // 12 beats against a 20-cycle waitrequest: FIFO fills and backpressures
      wr_force = 1'b1;
      frame(4, 12, 64'h4000);
      repeat (20) cyc();
      chk("t4_src_ready_full", src_ready, 1'b0);
      chk("t4_accepted_full", src_sent, 8);
      chk("t4_m_write_stalled", m_write, 1'b1);
      chk("t4_addr_stalled", m_address, 64'h4000);
      chk("t4_no_beats_yet", wr_data.size() - wb, 0);
      wr_force = 1'b0;
      run_done("t4", 100);
      chk("t4_accepted_all", src_sent, 12);
      chk("t4_nbursts", b_addr.size() - bb, 3);
      chk_burst("t4_b0", 0, 64'h4000, 4);
      chk_burst("t4_b1", 1, 64'h4100, 4);
      chk_burst("t4_b2", 2, 64'h4200, 4);
      chk_data("t4", 4, 12);
      chk("t4_beat_count", beat_count, 64'd12);

      // clear during the first burst: burst completes, then engine idles flushed
      frame(5, 8, 64'h5000);
      n = 0;
      while ((wr_data.size() - wb) < 1 && n < 40) begin
         cyc();
         n++;
      end
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         cyc();
         n++;
      end
      chk("t5_busy", busy, 1'b0);
      chk("t5_done", done, 1'b0);
      chk("t5_beat_count", beat_count, 64'd0);
      chk("t5_m_write", m_write, 1'b0);
      chk("t5_nbursts", b_addr.size() - bb, 1);
      chk_burst("t5_b0", 0, 64'h5000, 4);
      chk_data("t5", 5, 4);

      // 1-beat frame after the clear must not see stale FIFO contents
      frame(6, 1, 64'h6000);
      run_done("t5b", 20);
      chk("t5b_nbursts", b_addr.size() - bb, 1);
      chk_burst("t5b_b0", 0, 64'h6000, 1);
      chk_data("t5b", 6, 1);
      chk("t5b_beat_count", beat_count, 64'd1);

      // asynchronous reset in the middle of a burst
      frame(7, 8, 64'h7000);
      n = 0;
      while ((wr_data.size() - wb) < 1 && n < 40) begin
         cyc();
         n++;
      end
      chk("t6_in_burst", m_write, 1'b1);
      reset = 1'b0;
      src_total = 0; src_valid = 1'b0; src_eop = 1'b0; src_sop = 1'b0;
      m_waitrequest = 1'b0; left = 0;
      #1;
      chk("t6_m_write", m_write, 1'b0);
      chk("t6_m_read", m_read, 1'b0);
      chk("t6_burstcount", m_burstcount, 3'd1);
      chk("t6_address", m_address, 64'h0);
      chk("t6_byteenable", m_byteenable, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_src_ready", src_ready, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_beat_count", beat_count, 64'd0);
      #1;
      reset = 1'b1;
      cyc();
      frame(8, 1, 64'h8000);
      run_done("t6b", 20);
      chk("t6b_nbursts", b_addr.size() - bb, 1);
      chk_burst("t6b_b0", 0, 64'h8000, 1);
      chk_data("t6b", 8, 1);
      chk("t6b_beat_count", beat_count, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
